// File: rtl/run_detect_pkg.sv
// run_detect_pkg: shared FSM encoding and elaboration helpers for the run-detect arbiter
package run_detect_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DONE   = 2'd2
   } state_t;
   function automatic int clog2(input int v);
      for (int r = 0; r < 32; r++)
         if ((1 << r) >= v) return r;
      return 32;
   endfunction
endpackage

// File: rtl/run_detector.sv
// run_detector: saturating run-of-ones counter that flags each bit completing RUN_LEN ones
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   clr   : synchronous clear of the run (end of burst)
//   en    : a bit is accepted this cycle
//   din   : the accepted bit
//   hit   : combinational flag, accepted 1 that brings the run to RUN_LEN
module run_detector
   import run_detect_pkg::*;
#(
   parameter int RUN_LEN = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   input  logic din,
   output logic hit
);
   localparam int RW = clog2(RUN_LEN + 1);
   logic [RW-1:0] run, run_nxt;
   // the run parks at RUN_LEN so every further 1 keeps hitting
   always_comb begin
      run_nxt = din ? ((run == RW'(RUN_LEN)) ? run : run + RW'(1)) : '0;
      hit     = en & din & (run_nxt == RW'(RUN_LEN));
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset)   run <= '0;
      else if (clr) run <= '0;
      else if (en)  run <= run_nxt;
endmodule

// File: rtl/run_detect_arbiter.sv
// run_detect_arbiter: round-robin share of one run-of-ones detector between NUM_REQ serial lanes
//   clk, reset            : clock and asynchronous active-low reset
//   req_i/valid_i/bit_i/last_i : per-lane burst request, bit valid, bit, last-bit marker
//   ready_o, grant_o      : one-hot accept and grant of the lane being streamed
//   det_o, det_id_o       : registered detection pulse and its lane
//   done_o, done_id_o, done_cnt_o : burst-complete pulse, lane and saturated detection count
module run_detect_arbiter
   import run_detect_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int RUN_LEN   = 2,
   parameter int BURST_MAX = 8,
   parameter int CNT_W     = 4,
   parameter int ID_W      = clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [NUM_REQ-1:0] bit_i,
   input  logic [NUM_REQ-1:0] last_i,
   output logic [NUM_REQ-1:0] ready_o,
   output logic [NUM_REQ-1:0] grant_o,
   output logic               det_o,
   output logic [ID_W-1:0]    det_id_o,
   output logic               done_o,
   output logic [ID_W-1:0]    done_id_o,
   output logic [CNT_W-1:0]   done_cnt_o
);
   localparam int BW = clog2(BURST_MAX + 1);
   state_t            state, state_nxt;
   logic [ID_W-1:0]   g, last_g, pick, cand;
   logic [BW-1:0]     beat;
   logic [CNT_W-1:0]  cnt;
   logic              found, acc, fin, hit, streaming;
   // first requester strictly after the last one served, wrapping around
   always_comb begin
      pick  = last_g;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ID_W'((int'(last_g) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            pick  = cand;
            found = 1'b1;
         end
      end
   end
   always_comb begin
      streaming  = state == STREAM;
      acc        = streaming & valid_i[g] & req_i[g];
      fin        = streaming & ((acc & (last_i[g] | (beat == BW'(BURST_MAX - 1)))) | ~req_i[g]);
      state_nxt  = (state == IDLE) ? (|req_i ? STREAM : IDLE) :
                   (state == STREAM) ? (fin ? DONE : STREAM) : IDLE;
      grant_o    = streaming ? NUM_REQ'(1) << g : '0;
      ready_o    = grant_o;
      done_o     = state == DONE;
      done_id_o  = done_o ? g : '0;
      done_cnt_o = done_o ? cnt : '0;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         g        <= '0;
         last_g   <= ID_W'(NUM_REQ - 1);
         beat     <= '0;
         cnt      <= '0;
         det_o    <= 1'b0;
         det_id_o <= '0;
      end else begin
         det_o    <= hit;
         det_id_o <= hit ? g : '0;
         if (state == IDLE && |req_i) g <= pick;
         if (acc) beat <= beat + BW'(1);
         if (hit && cnt != '1) cnt <= cnt + CNT_W'(1);
         if (state == DONE) begin
            last_g <= g;
            beat   <= '0;
            cnt    <= '0;
         end
      end
   run_detector #(.RUN_LEN(RUN_LEN)) u_det (
      .clk   (clk),
      .reset (reset),
      .clr   (state == DONE),
      .en    (acc),
      .din   (bit_i[g]),
      .hit   (hit)
   );
endmodule

// File: tb/tb_run_detect_arbiter.sv
// tb_run_detect_arbiter: randomized scoreboard bench for run_detect_arbiter
module tb_run_detect_arbiter;
   localparam int N    = 4;
   localparam int RL   = 2;
   localparam int BM   = 8;
   localparam int CW   = 4;
   localparam int SBM  = 32;
   localparam int CMAX = (1 << CW) - 1;
   logic          clk = 1'b0, reset = 1'b0;
   logic [N-1:0]  req_i = '0, valid_i = '0, bit_i = '0, last_i = '0;
   logic [N-1:0]  ready_o, grant_o;
   logic          det_o, done_o;
   logic [1:0]    det_id_o, done_id_o;
   logic [CW-1:0] done_cnt_o;
   logic [N-1:0]  s_req = '0, s_valid = '0, s_bit = '0, s_last = '0;
   logic [N-1:0]  s_ready, s_grant;
   logic          s_det, s_done;
   logic [1:0]    s_det_id, s_done_id;
   logic [CW-1:0] s_done_cnt;
   int checks = 0, failures = 0;
   int exp_q[N][$];
   int sat_q[$];
   int gnt_log[$];
   int det_seen[N];
   int s_dets = 0;
   int last_g = N - 1, exp_g = 0;
   bit arb_pend = 0;
   always #5 clk = ~clk;
   run_detect_arbiter #(.NUM_REQ(N), .RUN_LEN(RL), .BURST_MAX(BM), .CNT_W(CW)) u_dut (
      .clk(clk), .reset(reset), .req_i(req_i), .valid_i(valid_i), .bit_i(bit_i), .last_i(last_i),
      .ready_o(ready_o), .grant_o(grant_o), .det_o(det_o), .det_id_o(det_id_o),
      .done_o(done_o), .done_id_o(done_id_o), .done_cnt_o(done_cnt_o));
   run_detect_arbiter #(.NUM_REQ(N), .RUN_LEN(RL), .BURST_MAX(SBM), .CNT_W(CW)) u_sat (
      .clk(clk), .reset(reset), .req_i(s_req), .valid_i(s_valid), .bit_i(s_bit), .last_i(s_last),
      .ready_o(s_ready), .grant_o(s_grant), .det_o(s_det), .det_id_o(s_det_id),
      .done_o(s_done), .done_id_o(s_done_id), .done_cnt_o(s_done_cnt));
   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask
   // a beat hits when it and the RUN_LEN-1 beats before it in this burst are all ones
   function automatic bit hit_at(input logic [31:0] b, input int k);
      if (k < RL - 1) return 1'b0;
      for (int j = 0; j < RL; j++)
         if (!b[k-j]) return 1'b0;
      return 1'b1;
   endfunction
   function automatic int count_hits(input logic [31:0] b, input int n);
      int h = 0;
      for (int k = 0; k < n; k++) h += int'(hit_at(b, k));
      return h;
   endfunction
   function automatic int rr(input logic [N-1:0] r, input int last);
      for (int i = 1; i <= N; i++)
         if (r[(last + i) % N]) return (last + i) % N;
      return 0;
   endfunction
   function automatic int idx_of(input logic [N-1:0] v);
      for (int i = 0; i < N; i++)
         if (v[i]) return i;
      return -1;
   endfunction
   task automatic chk_det(input int l, input bit e);
      chk("det_timing", det_o, e);
      if (e) chk("det_id", det_id_o, l);
   endtask
   task automatic run_burst(input int l, input logic [31:0] bits, input int len, input bit has_last, input int drop_k);
      logic [31:0] acc = '0;
      int n = 0, guard = 0;
      bit fin = 0, dropped = 0, fire = 0, ehit = 0, pend = 0;
      req_i[l] = 1'b1;
      while (!fin) begin
         if (drop_k != 0 && n == drop_k) begin
            req_i[l] = 1'b0;
            valid_i[l] = 1'b0;
            last_i[l] = 1'b0;
            fin = 1;
            dropped = 1;
         end else begin
            valid_i[l] = ($urandom_range(3) != 0);
            bit_i[l] = bits[n];
            last_i[l] = has_last && (n == len - 1);
            @(negedge clk);
            if (pend) begin
               chk_det(l, ehit);
               pend = 0;
            end
            fire = ready_o[l] & valid_i[l];
            @(posedge clk);
            #1;
            if (fire) begin
               acc[n] = bit_i[l];
               ehit = hit_at(acc, n);
               pend = 1;
               n++;
               fin = last_i[l] || n == BM;
            end
            guard++;
            if (guard > 2000) begin
               checks++;
               failures++;
               $display("FAIL burst_timeout: lane %0d accepted %0d of %0d bits", l, n, len);
               fin = 1;
            end
         end
      end
      exp_q[l].push_back(count_hits(acc, n));
      valid_i[l] = 1'b0;
      last_i[l] = 1'b0;
      @(negedge clk);
      if (pend) chk_det(l, ehit);
      if (!dropped) chk("ready_after_end", ready_o[l], 0);
      @(posedge clk);
      #1;
   endtask
   task automatic lane_loop(input int l, input int nb);
      for (int b = 0; b < nb; b++) begin
         int kind, gap;
         logic [31:0] bits;
         kind = $urandom_range(3);
         bits = $urandom | $urandom;
         if (kind < 2) run_burst(l, bits, $urandom_range(1, 12), 1, 0);
         else if (kind == 2) run_burst(l, bits, 12, 0, 0);
         else run_burst(l, bits, 12, 0, $urandom_range(1, BM - 1));
         gap = $urandom_range(2);
         if (gap != 0) begin
            req_i[l] = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
         end
      end
      req_i[l] = 1'b0;
   endtask
   task automatic pulse_reset();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask
   always @(negedge clk) begin
      int h;
      if (!reset) begin
         for (int i = 0; i < N; i++) det_seen[i] = 0;
         last_g = N - 1;
         arb_pend = 0;
      end else begin
         chk("ready_grant_onehot", ((ready_o & ~grant_o) != 0) || !$onehot0(grant_o), 0);
         if (arb_pend) begin
            chk("grant", grant_o, 1 << exp_g);
            gnt_log.push_back(idx_of(grant_o));
            arb_pend = 0;
         end else if (grant_o == 0 && !done_o && req_i != 0) begin
            exp_g = rr(req_i, last_g);
            arb_pend = 1;
         end
         if (det_o) det_seen[det_id_o]++;
         if (done_o) begin
            if (exp_q[done_id_o].size() == 0) begin
               checks++;
               failures++;
               $display("FAIL done_unexpected: lane %0d completed with no outstanding burst", done_id_o);
            end else begin
               h = exp_q[done_id_o].pop_front();
               chk("done_cnt", done_cnt_o, h > CMAX ? CMAX : h);
               chk("det_count", det_seen[done_id_o], h);
            end
            det_seen[done_id_o] = 0;
            last_g = done_id_o;
         end
      end
   end
   always @(negedge clk) begin
      int h;
      if (!reset) s_dets = 0;
      else begin
         if (s_det) s_dets++;
         if (s_done) begin
            if (sat_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sat_done_unexpected: lane %0d", s_done_id);
            end else begin
               h = sat_q.pop_front();
               chk("sat_done_id", s_done_id, 2);
               chk("sat_done_cnt", s_done_cnt, h > CMAX ? CMAX : h);
               chk("sat_det_count", s_dets, h);
            end
            s_dets = 0;
         end
      end
   end
   initial begin
      #400000;
      checks++;
      failures++;
      $display("FAIL watchdog: run exceeded its time limit");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      int order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
      int n;
      bit fire;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("reset_outputs", {grant_o, ready_o, det_o, det_id_o, done_o, done_id_o, done_cnt_o}, 0);
      @(posedge clk);
      #1;
      req_i[0] = 1'b1;
      valid_i[0] = 1'b1;
      bit_i[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("pre_abort_det", det_o, 1);
      chk("pre_abort_grant", grant_o, 1);
      #2;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_outputs", {grant_o, ready_o, det_o, det_id_o, done_o, done_id_o, done_cnt_o}, 0);
      req_i = '0;
      valid_i = '0;
      bit_i = '0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      fork
         run_burst(0, 32'b111011, 6, 1, 0);
         begin
            @(negedge clk);
            chk("arb_latency_idle", grant_o, 0);
            @(negedge clk);
            chk("grant_after_req", grant_o, 1);
         end
      join
      req_i[0] = 1'b0;
      run_burst(1, 32'b1, 3, 0, 1);
      run_burst(1, 32'b11, 2, 1, 0);
      req_i[1] = 1'b0;
      run_burst(2, 32'h3FF, 10, 0, 0);
      req_i[2] = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();
      gnt_log.delete();
      fork
         begin run_burst(0, 32'b1, 1, 1, 0); run_burst(0, 32'b1, 1, 1, 0); req_i[0] = 1'b0; end
         begin run_burst(1, 32'b1, 1, 1, 0); run_burst(1, 32'b1, 1, 1, 0); req_i[1] = 1'b0; end
         begin run_burst(2, 32'b1, 1, 1, 0); run_burst(2, 32'b1, 1, 1, 0); req_i[2] = 1'b0; end
         begin run_burst(3, 32'b1, 1, 1, 0); run_burst(3, 32'b1, 1, 1, 0); req_i[3] = 1'b0; end
      join
      chk("grant_order_len", gnt_log.size(), 8);
      for (int i = 0; i < 8 && i < gnt_log.size(); i++) chk("grant_order", gnt_log[i], order[i]);
      fork
         lane_loop(0, 10);
         lane_loop(1, 10);
         lane_loop(2, 10);
         lane_loop(3, 10);
      join
      repeat (3) @(posedge clk);
      #1;
      s_req[2] = 1'b1;
      s_valid[2] = 1'b1;
      s_bit[2] = 1'b1;
      n = 0;
      for (int t = 0; t < 200 && n < 20; t++) begin
         s_last[2] = (n == 19);
         @(negedge clk);
         fire = s_ready[2];
         @(posedge clk);
         #1;
         if (fire) n++;
      end
      sat_q.push_back(count_hits(32'hFFFFF, n));
      s_req = '0;
      s_valid = '0;
      s_last = '0;
      chk("sat_beats", n, 20);
      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N; i++) chk("pending_done", exp_q[i].size(), 0);
      chk("sat_pending_done", sat_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
